// File: rtl/unidad_control.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit UAZ microprocessor.
// Sequences program fetch, register writes and data-memory handshakes, with a
// handshake timeout that drops the core into a sticky error state.
module unidad_control #(
    parameter int unsigned              ANCHO_PC   = 8,
    parameter logic [ANCHO_PC-1:0]      DIR_INICIO = '0,
    parameter int unsigned              MAX_ESPERA = 15
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Inicio,
    output logic [ANCHO_PC-1:0] o_Direccion_PC,
    output logic                o_Leer_Prog,
    input  logic                i_Prog_Valido,
    input  logic [15:0]         i_Instruccion,
    input  logic [ANCHO_PC-1:0] i_Direccion_Salto,
    input  logic                i_Bandera_Cero,
    output logic [8:0]          o_Instrucciones,
    output logic                o_Control_Registros,
    output logic                o_Escribir_Reg,
    output logic [3:0]          o_Op_ALU,
    output logic                o_Leer_Dato,
    output logic                o_Escribir_Dato,
    input  logic                i_Dato_Listo,
    output logic                o_Detenido,
    output logic                o_Error
);

    localparam int unsigned ANCHO_CNT = $clog2(MAX_ESPERA + 1);
    localparam logic [ANCHO_CNT-1:0] LIMITE = ANCHO_CNT'(MAX_ESPERA - 1);

    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        REPOSO,
        BUSCAR,
        DECODIFICAR,
        EJECUTAR,
        MEMORIA,
        ESCRIBIR,
        DETENIDO,
        ERROR
    } estado_t;

    estado_t                estado_q;
    logic [ANCHO_PC-1:0]    pc_q;
    logic [15:3]            ir_q;
    logic [ANCHO_CNT-1:0]   cnt_q;
    logic                   leer_prog_q;
    logic                   leer_dato_q;
    logic                   escribir_dato_q;
    logic                   escribir_reg_q;
    logic                   control_reg_q;
    logic [3:0]             op_alu_q;
    logic                   detenido_q;
    logic                   error_q;

    logic [3:0]             opcode;
    logic                   es_alu;
    logic [ANCHO_PC-1:0]    pc_mas_uno;
    logic                   bits_unused;

    // Decode helpers from the latched instruction word
    assign opcode      = ir_q[15:12];
    assign es_alu      = (ir_q[15] == 1'b0) && (ir_q[14:12] != 3'b000);
    assign pc_mas_uno  = pc_q + ANCHO_PC'(1);
    assign bits_unused = ^i_Instruccion[2:0];

    // Controller state machine; outputs are registered alongside the state
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            estado_q        <= REPOSO;
            pc_q            <= DIR_INICIO;
            ir_q            <= '0;
            cnt_q           <= '0;
            leer_prog_q     <= 1'b0;
            leer_dato_q     <= 1'b0;
            escribir_dato_q <= 1'b0;
            escribir_reg_q  <= 1'b0;
            control_reg_q   <= 1'b0;
            op_alu_q        <= 4'h0;
            detenido_q      <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            escribir_reg_q <= 1'b0;
            control_reg_q  <= 1'b0;
            op_alu_q       <= 4'h0;
            case (estado_q)
                REPOSO: begin
                    if (i_Inicio) begin
                        estado_q    <= BUSCAR;
                        leer_prog_q <= 1'b1;
                    end
                end
                BUSCAR: begin
                    if (i_Prog_Valido) begin
                        ir_q        <= i_Instruccion[15:3];
                        cnt_q       <= '0;
                        leer_prog_q <= 1'b0;
                        estado_q    <= DECODIFICAR;
                    end else if (cnt_q == LIMITE) begin
                        leer_prog_q <= 1'b0;
                        error_q     <= 1'b1;
                        detenido_q  <= 1'b1;
                        estado_q    <= ERROR;
                    end else begin
                        cnt_q <= cnt_q + ANCHO_CNT'(1);
                    end
                end
                DECODIFICAR: begin
                    estado_q <= EJECUTAR;
                    if (es_alu) begin
                        op_alu_q       <= opcode;
                        control_reg_q  <= 1'b1;
                        escribir_reg_q <= 1'b1;
                    end
                end
                EJECUTAR: begin
                    case (opcode)
                        OP_LD: begin
                            leer_dato_q <= 1'b1;
                            estado_q    <= MEMORIA;
                        end
                        OP_ST: begin
                            escribir_dato_q <= 1'b1;
                            estado_q        <= MEMORIA;
                        end
                        OP_JMP: begin
                            pc_q        <= i_Direccion_Salto;
                            leer_prog_q <= 1'b1;
                            estado_q    <= BUSCAR;
                        end
                        OP_JZ: begin
                            pc_q        <= i_Bandera_Cero ? i_Direccion_Salto : pc_mas_uno;
                            leer_prog_q <= 1'b1;
                            estado_q    <= BUSCAR;
                        end
                        OP_HLT: begin
                            detenido_q <= 1'b1;
                            estado_q   <= DETENIDO;
                        end
                        default: begin
                            // NOP, ALU ops and illegal opcodes all advance the PC
                            pc_q        <= pc_mas_uno;
                            leer_prog_q <= 1'b1;
                            estado_q    <= BUSCAR;
                        end
                    endcase
                end
                MEMORIA: begin
                    if (i_Dato_Listo) begin
                        leer_dato_q     <= 1'b0;
                        escribir_dato_q <= 1'b0;
                        cnt_q           <= '0;
                        if (opcode == OP_LD) begin
                            escribir_reg_q <= 1'b1;
                            estado_q       <= ESCRIBIR;
                        end else begin
                            pc_q        <= pc_mas_uno;
                            leer_prog_q <= 1'b1;
                            estado_q    <= BUSCAR;
                        end
                    end else if (cnt_q == LIMITE) begin
                        leer_dato_q     <= 1'b0;
                        escribir_dato_q <= 1'b0;
                        error_q         <= 1'b1;
                        detenido_q      <= 1'b1;
                        estado_q        <= ERROR;
                    end else begin
                        cnt_q <= cnt_q + ANCHO_CNT'(1);
                    end
                end
                ESCRIBIR: begin
                    pc_q        <= pc_mas_uno;
                    leer_prog_q <= 1'b1;
                    estado_q    <= BUSCAR;
                end
                DETENIDO, ERROR: begin
                    estado_q <= estado_q;
                end
                default: begin
                    estado_q <= REPOSO;
                end
            endcase
        end
    end

    assign o_Direccion_PC      = pc_q;
    assign o_Leer_Prog         = leer_prog_q;
    assign o_Instrucciones     = ir_q[11:3];
    assign o_Control_Registros = control_reg_q;
    assign o_Escribir_Reg      = escribir_reg_q;
    assign o_Op_ALU            = op_alu_q;
    assign o_Leer_Dato         = leer_dato_q;
    assign o_Escribir_Dato     = escribir_dato_q;
    assign o_Detenido          = detenido_q;
    assign o_Error             = error_q;

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control: table of instruction vectors plus
// hand-written sequences for reset, timeout and mid-handshake reset.
module tb_unidad_control;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_Inicio;
    logic [7:0]  o_Direccion_PC;
    logic        o_Leer_Prog;
    logic        i_Prog_Valido;
    logic [15:0] i_Instruccion;
    logic [7:0]  i_Direccion_Salto;
    logic        i_Bandera_Cero;
    logic [8:0]  o_Instrucciones;
    logic        o_Control_Registros;
    logic        o_Escribir_Reg;
    logic [3:0]  o_Op_ALU;
    logic        o_Leer_Dato;
    logic        o_Escribir_Dato;
    logic        i_Dato_Listo;
    logic        o_Detenido;
    logic        o_Error;

    int checks = 0;
    int errors = 0;

    unidad_control dut (
        .i_Clk               (i_Clk),
        .i_Rst               (i_Rst),
        .i_Inicio            (i_Inicio),
        .o_Direccion_PC      (o_Direccion_PC),
        .o_Leer_Prog         (o_Leer_Prog),
        .i_Prog_Valido       (i_Prog_Valido),
        .i_Instruccion       (i_Instruccion),
        .i_Direccion_Salto   (i_Direccion_Salto),
        .i_Bandera_Cero      (i_Bandera_Cero),
        .o_Instrucciones     (o_Instrucciones),
        .o_Control_Registros (o_Control_Registros),
        .o_Escribir_Reg      (o_Escribir_Reg),
        .o_Op_ALU            (o_Op_ALU),
        .o_Leer_Dato         (o_Leer_Dato),
        .o_Escribir_Dato     (o_Escribir_Dato),
        .i_Dato_Listo        (i_Dato_Listo),
        .o_Detenido          (o_Detenido),
        .o_Error             (o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  salto;
        logic        cero;
        int          espera;
        logic [7:0]  pc;
        logic [8:0]  i9;
        int          wr;
        logic        ctrl;
        logic [3:0]  op;
        int          mem;
        logic [7:0]  npc;
        logic        halt;
    } vec_t;

    vec_t tabla [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Rst = 1'b0;
        i_Inicio = 1'b0;
        i_Prog_Valido = 1'b0;
        i_Dato_Listo = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_Rst = 1'b1;
    endtask

    task automatic do_start();
        i_Inicio = 1'b1;
        @(negedge i_Clk);
        i_Inicio = 1'b0;
    endtask

    // All outputs at reset values (PC at start address)
    task automatic chk_reposo(input string tag);
        chk({tag, "_pc"}, 32'(o_Direccion_PC), 32'h00);
        chk({tag, "_outs"}, 32'({o_Leer_Prog, o_Instrucciones, o_Control_Registros, o_Escribir_Reg,
                                 o_Op_ALU, o_Leer_Dato, o_Escribir_Dato, o_Detenido, o_Error}), 32'h0);
    endtask

    // Runs one instruction starting at a negedge where a fetch is pending
    task automatic run_vec(input int idx, input vec_t v);
        int   cyc;
        int   wr_cnt;
        int   mem_cnt;
        logic ctrl_s;
        logic [3:0] op_s;
        logic excl_bad;
        logic done;
        string n;
        n = $sformatf("v%0d", idx);
        wr_cnt = 0; mem_cnt = 0; ctrl_s = 1'b0; op_s = 4'h0; excl_bad = 1'b0; done = 1'b0;
        i_Direccion_Salto = v.salto;
        i_Bandera_Cero    = v.cero;
        chk({n, "_fetch_req"}, 32'(o_Leer_Prog), 32'h1);
        chk({n, "_fetch_pc"}, 32'(o_Direccion_PC), 32'(v.pc));
        i_Prog_Valido = 1'b1;
        i_Instruccion = v.instr;
        @(negedge i_Clk);
        i_Prog_Valido = 1'b0;
        i_Instruccion = 16'hxxxx;
        chk({n, "_instrucciones"}, 32'(o_Instrucciones), 32'(v.i9));
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge i_Clk);
            cyc++;
            i_Dato_Listo = 1'b0;
            if ((32'(o_Leer_Prog) + 32'(o_Leer_Dato) + 32'(o_Escribir_Dato)) > 1) excl_bad = 1'b1;
            if (o_Escribir_Reg) begin
                wr_cnt++;
                ctrl_s = o_Control_Registros;
                op_s   = o_Op_ALU;
            end
            if (o_Leer_Dato || o_Escribir_Dato) begin
                mem_cnt++;
                if (mem_cnt == v.espera + 1) i_Dato_Listo = 1'b1;
            end
            if (o_Leer_Prog || o_Detenido) done = 1'b1;
        end
        chk({n, "_finished"}, 32'(done), 32'h1);
        chk({n, "_wr_count"}, 32'(wr_cnt), 32'(v.wr));
        chk({n, "_ctrl"}, 32'(ctrl_s), 32'(v.ctrl));
        chk({n, "_op"}, 32'(op_s), 32'(v.op));
        chk({n, "_mem_cycles"}, 32'(mem_cnt), 32'(v.mem));
        chk({n, "_next_pc"}, 32'(o_Direccion_PC), 32'(v.npc));
        chk({n, "_halt"}, 32'(o_Detenido), 32'(v.halt));
        chk({n, "_exclusive"}, 32'(excl_bad), 32'h0);
    endtask

    initial begin
        int n_fetch;
        //            instr    salto  cero esp pc     i9            wr ctrl  op    mem npc    halt
        tabla[0]  = '{16'h1298, 8'h00, 1'b0, 0, 8'h00, 9'b001010011, 1, 1'b1, 4'h1, 0, 8'h01, 1'b0};
        tabla[1]  = '{16'h8A00, 8'h00, 1'b0, 3, 8'h01, 9'b101000000, 1, 1'b0, 4'h0, 4, 8'h02, 1'b0};
        tabla[2]  = '{16'h9400, 8'h00, 1'b0, 0, 8'h02, 9'b010000000, 0, 1'b0, 4'h0, 1, 8'h03, 1'b0};
        tabla[3]  = '{16'hB000, 8'h40, 1'b1, 0, 8'h03, 9'b000000000, 0, 1'b0, 4'h0, 0, 8'h40, 1'b0};
        tabla[4]  = '{16'hB000, 8'h40, 1'b0, 0, 8'h40, 9'b000000000, 0, 1'b0, 4'h0, 0, 8'h41, 1'b0};
        tabla[5]  = '{16'h2E3F, 8'h00, 1'b0, 0, 8'h41, 9'b111000111, 1, 1'b1, 4'h2, 0, 8'h42, 1'b0};
        tabla[6]  = '{16'hC000, 8'h00, 1'b0, 0, 8'h42, 9'b000000000, 0, 1'b0, 4'h0, 0, 8'h43, 1'b0};
        tabla[7]  = '{16'hA000, 8'hFF, 1'b0, 0, 8'h43, 9'b000000000, 0, 1'b0, 4'h0, 0, 8'hFF, 1'b0};
        tabla[8]  = '{16'h0000, 8'h00, 1'b0, 0, 8'hFF, 9'b000000000, 0, 1'b0, 4'h0, 0, 8'h00, 1'b0};
        tabla[9]  = '{16'h7FFF, 8'h00, 1'b0, 0, 8'h00, 9'b111111111, 1, 1'b1, 4'h7, 0, 8'h01, 1'b0};
        tabla[10] = '{16'hF000, 8'h00, 1'b0, 0, 8'h01, 9'b000000000, 0, 1'b0, 4'h0, 0, 8'h01, 1'b1};

        i_Rst = 1'b1; i_Inicio = 1'b0; i_Prog_Valido = 1'b0; i_Instruccion = 16'h0;
        i_Direccion_Salto = 8'h00; i_Bandera_Cero = 1'b0; i_Dato_Listo = 1'b0;

        // Reset state, and staying idle without i_Inicio
        do_reset();
        chk_reposo("reset");
        @(negedge i_Clk);
        @(negedge i_Clk);
        chk_reposo("idle_no_start");

        // Table-driven program
        do_start();
        for (int i = 0; i < 11; i++) run_vec(i, tabla[i]);

        // After HLT: no further fetches, outputs frozen
        n_fetch = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_Clk);
            if (o_Leer_Prog) n_fetch++;
        end
        chk("hlt_no_fetch", 32'(n_fetch), 32'h0);
        chk("hlt_detenido", 32'(o_Detenido), 32'h1);
        chk("hlt_no_error", 32'(o_Error), 32'h0);
        chk("hlt_pc_frozen", 32'(o_Direccion_PC), 32'h01);

        // Fetch timeout: program memory never answers
        do_reset();
        do_start();
        n_fetch = 0;
        for (int i = 0; i < 40 && o_Leer_Prog; i++) begin
            n_fetch++;
            @(negedge i_Clk);
        end
        chk("timeout_wait_cycles", 32'(n_fetch), 32'd15);
        chk("timeout_error", 32'(o_Error), 32'h1);
        chk("timeout_detenido", 32'(o_Detenido), 32'h1);
        chk("timeout_leer_prog", 32'(o_Leer_Prog), 32'h0);
        i_Inicio = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge i_Clk);
        i_Inicio = 1'b0;
        chk("error_sticky", 32'({o_Error, o_Detenido, o_Leer_Prog}), 32'b110);
        do_reset();
        chk_reposo("after_error_reset");

        // Reset while waiting on a data-memory load
        do_start();
        i_Prog_Valido = 1'b1;
        i_Instruccion = 16'h8A00;
        @(negedge i_Clk);
        i_Prog_Valido = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        chk("mem_wait_leer_dato", 32'(o_Leer_Dato), 32'h1);
        @(negedge i_Clk);
        @(negedge i_Clk);
        chk("mem_wait_still", 32'(o_Leer_Dato), 32'h1);
        i_Rst = 1'b0;
        @(negedge i_Clk);
        i_Rst = 1'b1;
        chk_reposo("mem_reset");
        @(negedge i_Clk);
        chk("mem_reset_stays_idle", 32'(o_Leer_Prog), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
